// File: rtl/stream_frame_packer_pkg.sv
// Shared types and constants for the stream frame packer: FSM states,
// channel ids of the captured AXI beats and the trailer beat layout.
package stream_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2,
    CHKSUM  = 2'd3
  } state_t;

  // Channel ids carried on s_axis_tuser by the upstream converter.
  localparam logic [2:0] CH_AR = 3'd0;
  localparam logic [2:0] CH_AW = 3'd1;
  localparam logic [2:0] CH_R  = 3'd2;
  localparam logic [2:0] CH_W  = 3'd3;
  localparam logic [2:0] CH_B  = 3'd4;

  // Trailer field positions within the low 64 bits of the beat.
  localparam int TRL_MAGIC_LSB = 48;
  localparam int TRL_SEQ_LSB   = 32;
  localparam int TRL_CNT_LSB   = 16;
  localparam int TRL_MASK_LSB  = 8;
  localparam int TRL_CHK_BIT   = 1;
  localparam int TRL_TO_BIT    = 0;

  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] seq;
    logic [15:0] beat_cnt;
    logic [7:0]  ch_mask;
    logic [5:0]  rsvd;
    logic        chk;
    logic        timeout;
  } trailer_t;

  // Assemble a trailer word; reserved bits are always zero.
  function automatic trailer_t build_trailer(
    input logic [15:0] magic,
    input logic [15:0] seq,
    input logic [15:0] beat_cnt,
    input logic [7:0]  ch_mask,
    input logic        chk,
    input logic        timeout
  );
    logic [63:0] w;
    w = '0;
    w[TRL_MAGIC_LSB +: 16] = magic;
    w[TRL_SEQ_LSB +: 16]   = seq;
    w[TRL_CNT_LSB +: 16]   = beat_cnt;
    w[TRL_MASK_LSB +: 8]   = ch_mask;
    w[TRL_CHK_BIT]         = chk;
    w[TRL_TO_BIT]          = timeout;
    return trailer_t'(w);
  endfunction

endpackage

// File: rtl/stream_frame_packer_out_slot.sv
// One-entry registered AXI4-Stream output slot. Contents are held while the
// consumer stalls; the owner may only load when 'free' is high.
module stream_frame_packer_out_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         last,
  output logic         free
);

  // The slot can take a new beat if empty or emptying this cycle.
  assign free = !valid || ready;

  // Load a new beat, or drop the current one once it has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_frame_packer.sv
// Groups captured AXI channel beats into bounded frames, each closed by a
// trailer beat (magic, sequence, beat count, channel mask, close reason).
// Optional build macro STREAM_FRAME_PACKER_CHKSUM_EN appends a beat holding
// the XOR of all payload beats after the trailer.
module stream_frame_packer
  import stream_frame_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          CH_W      = 3,
  parameter int          MAX_BEATS = 32,
  parameter int          TIMEOUT   = 256,
  parameter logic [15:0] MAGIC     = 16'hE7A1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]   s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
  localparam logic [15:0]       MAX_CNT    = 16'(MAX_BEATS);
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
  localparam logic CHK_PRESENT = 1'b1;
`else
  localparam logic CHK_PRESENT = 1'b0;
`endif

  state_t              state_reg, state_next;
  logic [15:0]         seq_reg, seq_next;
  logic [15:0]         beat_cnt_reg, beat_cnt_next;
  logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [7:0]          ch_mask_reg, ch_mask_next;
  logic                timeout_reg, timeout_next;
  logic                tail_loaded_reg, tail_loaded_next;
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
  logic [DATA_W-1:0]   xor_reg, xor_next;
`endif

  logic                slot_free;
  logic                slot_load;
  logic [DATA_W-1:0]   slot_data;
  logic                slot_last;
  logic                accept;
  logic                out_hs;
  logic                last_beat;
  logic                frame_done;
  logic [63:0]         trailer_word;
  logic [DATA_W-1:0]   trailer_data;

  // Input is taken only while collecting a frame and the output slot can
  // absorb the beat; forced low while reset is held.
  assign s_axis_tready = aresetn && ((state_reg == IDLE) || (state_reg == PAYLOAD)) && slot_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (beat_cnt_reg + 16'd1) == MAX_CNT;
  assign busy          = (state_reg != IDLE) || m_axis_tvalid;

  assign trailer_word = build_trailer(MAGIC, seq_reg, beat_cnt_reg, ch_mask_reg,
                                      CHK_PRESENT, timeout_reg);
  assign trailer_data = DATA_W'(trailer_word);

  stream_frame_packer_out_slot #(
    .W(DATA_W)
  ) u_out_slot (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (slot_load),
    .load_data (slot_data),
    .load_last (slot_last),
    .ready     (m_axis_tready),
    .data      (m_axis_tdata),
    .valid     (m_axis_tvalid),
    .last      (m_axis_tlast),
    .free      (slot_free)
  );

  // Frame state register and counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      seq_reg         <= '0;
      beat_cnt_reg    <= '0;
      idle_cnt_reg    <= '0;
      ch_mask_reg     <= '0;
      timeout_reg     <= 1'b0;
      tail_loaded_reg <= 1'b0;
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
      xor_reg         <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      seq_reg         <= seq_next;
      beat_cnt_reg    <= beat_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      ch_mask_reg     <= ch_mask_next;
      timeout_reg     <= timeout_next;
      tail_loaded_reg <= tail_loaded_next;
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
      xor_reg         <= xor_next;
`endif
    end
  end

  // Next-state logic: payload pass-through, frame close decisions and
  // trailer (plus optional checksum) emission.
  always_comb begin
    state_next       = state_reg;
    seq_next         = seq_reg;
    beat_cnt_next    = beat_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    ch_mask_next     = ch_mask_reg;
    timeout_next     = timeout_reg;
    tail_loaded_next = tail_loaded_reg;
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
    xor_next         = xor_reg;
`endif
    slot_load        = 1'b0;
    slot_data        = s_axis_tdata;
    slot_last        = 1'b0;
    frame_done       = 1'b0;

    // Every accepted beat goes straight to the slot; an accept always
    // restarts the idle timer, even on the cycle it would have expired.
    if (accept) begin
      slot_load     = 1'b1;
      beat_cnt_next = beat_cnt_reg + 16'd1;
      ch_mask_next  = ch_mask_reg | (8'd1 << s_axis_tuser);
      idle_cnt_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
          xor_next = s_axis_tdata;
`endif
          if (last_beat) begin
            state_next   = TRAILER;
            timeout_next = 1'b0;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
          xor_next = xor_reg ^ s_axis_tdata;
`endif
          if (last_beat) begin
            state_next   = TRAILER;
            timeout_next = 1'b0;
          end
        end else if (idle_cnt_reg == IDLE_LIMIT) begin
          state_next   = TRAILER;
          timeout_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
      end

      TRAILER: begin
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
        // Trailer is not the last beat; the checksum beat follows it.
        if (slot_free) begin
          slot_load  = 1'b1;
          slot_data  = trailer_data;
          slot_last  = 1'b0;
          state_next = CHKSUM;
        end
`else
        if (!tail_loaded_reg && slot_free) begin
          slot_load        = 1'b1;
          slot_data        = trailer_data;
          slot_last        = 1'b1;
          tail_loaded_next = 1'b1;
        end else if (tail_loaded_reg && out_hs) begin
          frame_done = 1'b1;
        end
`endif
      end

`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
      CHKSUM: begin
        if (!tail_loaded_reg && slot_free) begin
          slot_load        = 1'b1;
          slot_data        = xor_reg;
          slot_last        = 1'b1;
          tail_loaded_next = 1'b1;
        end else if (tail_loaded_reg && out_hs) begin
          frame_done = 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // The final beat of the frame has left: start a fresh frame.
    if (frame_done) begin
      state_next       = IDLE;
      seq_next         = seq_reg + 16'd1;
      beat_cnt_next    = '0;
      idle_cnt_next    = '0;
      ch_mask_next     = '0;
      timeout_next     = 1'b0;
      tail_loaded_next = 1'b0;
`ifdef STREAM_FRAME_PACKER_CHKSUM_EN
      xor_next         = '0;
`endif
    end
  end

endmodule
